// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: operation codes, FSM encoding
// and the default acknowledge timeout.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LW   = 3'd1,
    OP_SW   = 3'd2,
    OP_LB   = 3'd3,
    OP_LBU  = 3'd4,
    OP_SB   = 3'd5
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int ACK_TIMEOUT_DEF = 16;

  // Codes 6 and 7 are reserved and behave exactly like NONE.
  function automatic mem_op_e decode_op(input logic [2:0] code);
    mem_op_e op;
    case (code)
      3'd1:    op = OP_LW;
      3'd2:    op = OP_SW;
      3'd3:    op = OP_LB;
      3'd4:    op = OP_LBU;
      3'd5:    op = OP_SB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_word(input mem_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_lane.sv
// Byte-lane steering for the data RAM: byte enables, store-byte replication
// and load sign/zero extension. Purely combinational.
module mem_lane
  import mem_stage_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  mem_op_e    op;
  logic [7:0] lane_byte;

  assign op = decode_op(op_i);

  always_comb begin
    lane_byte = rdata_i[7:0];
    case (lane_i)
      2'd0: lane_byte = rdata_i[7:0];
      2'd1: lane_byte = rdata_i[15:8];
      2'd2: lane_byte = rdata_i[23:16];
      2'd3: lane_byte = rdata_i[31:24];
      default: lane_byte = rdata_i[7:0];
    endcase
  end

  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (op)
      OP_LW, OP_SW: be_o = 4'b1111;
      OP_LB, OP_LBU, OP_SB: be_o = 4'b0001 << lane_i;
      default: be_o = 4'b0000;
    endcase
    if (op == OP_SB) begin
      wdata_o = {4{store_data_i[7:0]}};
    end
    if (op == OP_LB) begin
      load_data_o = {{24{lane_byte[7]}}, lane_byte};
    end else if (op == OP_LBU) begin
      load_data_o = {24'h000000, lane_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-RAM access at a time, waits for a
// one-cycle acknowledge (with timeout) and registers the write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [2:0]  memOp,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] storeData,
  input  logic        regcWr_i,
  input  logic [4:0]  regcAddr_i,
  input  logic [31:0] regcData_i,
  output logic        stall,
  output logic        regcWr,
  output logic [4:0]  regcAddr,
  output logic [31:0] regcData,
  output logic        memCe,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memBe,
  input  logic [31:0] memRData,
  input  logic        memAck,
  output logic        alignErr,
  output logic        busErr,
  output logic        dbg_state_o
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  mem_op_e        op_q, op_d;
  logic [31:2]    addr_q, addr_d;
  logic [1:0]     lane_q, lane_d;
  logic [4:0]     rd_q, rd_d;
  logic [3:0]     be_q, be_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           regc_wr_q, regc_wr_d;
  logic [4:0]     regc_addr_q, regc_addr_d;
  logic [31:0]    regc_data_q, regc_data_d;

  mem_op_e        op_in;
  logic           misalign;
  logic [2:0]     lane_op;
  logic [1:0]     lane_sel;
  logic [3:0]     lane_be;
  logic [31:0]    lane_wdata;
  logic [31:0]    lane_load;

  assign op_in    = decode_op(memOp);
  assign misalign = is_word(op_in) && (memAddr_i[1:0] != 2'b00);

  // The lane unit sees the incoming op while IDLE (to latch enables and
  // write data) and the latched op while WAIT (to extend the read data).
  assign lane_op  = (state_q == ST_WAIT) ? op_q : memOp;
  assign lane_sel = (state_q == ST_WAIT) ? lane_q : memAddr_i[1:0];

  mem_lane u_lane (
    .op_i         (lane_op),
    .lane_i       (lane_sel),
    .store_data_i (storeData),
    .rdata_i      (memRData),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_load)
  );

  // Handshake: upstream holds its inputs while stall=1 and advances on any
  // cycle with stall=0; memAck is a single-cycle pulse, honoured only in WAIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    regc_wr_d   = 1'b0;
    regc_addr_d = regc_addr_q;
    regc_data_d = regc_data_q;
    stall       = 1'b0;
    alignErr    = 1'b0;
    busErr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          if (op_in == OP_NONE) begin
            regc_wr_d   = regcWr_i;
            regc_addr_d = regcAddr_i;
            regc_data_d = regcData_i;
          end else if (misalign) begin
            alignErr = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = '0;
            op_d    = op_in;
            addr_d  = memAddr_i[31:2];
            lane_d  = memAddr_i[1:0];
            rd_d    = regcAddr_i;
            be_d    = lane_be;
            wdata_d = lane_wdata;
          end
        end
      end
      ST_WAIT: begin
        if (memAck) begin
          state_d = ST_IDLE;
          if (is_load(op_q)) begin
            regc_wr_d   = 1'b1;
            regc_addr_d = rd_q;
            regc_data_d = lane_load;
          end
        end else if (cnt_q == CNT_LAST) begin
          busErr  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NONE;
      addr_q      <= '0;
      lane_q      <= '0;
      rd_q        <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      regc_wr_q   <= 1'b0;
      regc_addr_q <= '0;
      regc_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      regc_wr_q   <= regc_wr_d;
      regc_addr_q <= regc_addr_d;
      regc_data_q <= regc_data_d;
    end
  end

  assign memCe       = (state_q == ST_WAIT);
  assign memWe       = (state_q == ST_WAIT) && is_store(op_q);
  assign memBe       = (state_q == ST_WAIT) ? be_q : 4'b0000;
  assign memAddr     = {addr_q, 2'b00};
  assign memWData    = wdata_q;
  assign regcWr      = regc_wr_q;
  assign regcAddr    = regc_addr_q;
  assign regcData    = regc_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle IDLE vectors plus
// hand-written multi-cycle access, timeout and reset sequences.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [2:0]  memOp;
  logic [31:0] memAddr_i;
  logic [31:0] storeData;
  logic        regcWr_i;
  logic [4:0]  regcAddr_i;
  logic [31:0] regcData_i;
  logic        stall;
  logic        regcWr;
  logic [4:0]  regcAddr;
  logic [31:0] regcData;
  logic        memCe;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memBe;
  logic [31:0] memRData;
  logic        memAck;
  logic        alignErr;
  logic        busErr;
  logic        dbg_state_o;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .inValid     (inValid),
    .memOp       (memOp),
    .memAddr_i   (memAddr_i),
    .storeData   (storeData),
    .regcWr_i    (regcWr_i),
    .regcAddr_i  (regcAddr_i),
    .regcData_i  (regcData_i),
    .stall       (stall),
    .regcWr      (regcWr),
    .regcAddr    (regcAddr),
    .regcData    (regcData),
    .memCe       (memCe),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWData    (memWData),
    .memBe       (memBe),
    .memRData    (memRData),
    .memAck      (memAck),
    .alignErr    (alignErr),
    .busErr      (busErr),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Results captured by do_access
  int          g_stall, g_waits, g_bus;
  logic        g_ce_idle, g_ce, g_we, g_stable, g_wr_wait, g_ce_after;
  logic [3:0]  g_be;
  logic [31:0] g_addr, g_wdata;

  // Issue one memory op from IDLE; ack_at is the WAIT cycle (1-based) carrying
  // memAck, 0 means never acknowledge.
  task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [4:0] rd,
                           input int ack_at, input logic [31:0] rdata);
    g_stall = 0; g_waits = 0; g_bus = 0; g_stable = 1'b1;
    inValid = 1'b1; memOp = op; memAddr_i = addr; storeData = sd;
    regcWr_i = 1'b1; regcAddr_i = rd; regcData_i = 32'hDEAD_BEEF;
    #1;
    g_ce_idle = memCe;
    if (stall) g_stall++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      inValid = 1'b0; memOp = 3'd0; memAddr_i = 32'hFFFF_FFFF; storeData = 32'h0;
      memAck = (k == ack_at);
      memRData = (k == ack_at) ? rdata : 32'h5A5A_5A5A;
      #1;
      if (k == 1) begin
        g_ce = memCe; g_we = memWe; g_be = memBe; g_addr = memAddr; g_wdata = memWData;
        g_wr_wait = regcWr;
      end else if ({memCe, memWe, memBe, memAddr, memWData} !== {g_ce, g_we, g_be, g_addr, g_wdata}) begin
        g_stable = 1'b0;
      end
      g_waits = k;
      if (stall) g_stall++;
      if (busErr) g_bus++;
      if (memAck || busErr) break;
    end
    @(posedge clk); #1;
    memAck = 1'b0;
    g_ce_after = memCe;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        wr;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        e_stall;
    logic        e_align;
    logic        e_wr;
    logic [4:0]  e_ra;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 3'd0, 32'h0000_0000, 1'b1, 5'd5,  32'h1111_1111, 1'b0, 1'b0, 1'b1, 5'd5,  32'h1111_1111};
    vecs[1] = '{1'b0, 3'd1, 32'h0000_0100, 1'b1, 5'd6,  32'h0000_0099, 1'b0, 1'b0, 1'b0, 5'd5,  32'h1111_1111};
    vecs[2] = '{1'b1, 3'd0, 32'h0000_0000, 1'b0, 5'd7,  32'h0000_0022, 1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0022};
    vecs[3] = '{1'b1, 3'd6, 32'h0000_0104, 1'b1, 5'd9,  32'h0000_CAFE, 1'b0, 1'b0, 1'b1, 5'd9,  32'h0000_CAFE};
    vecs[4] = '{1'b1, 3'd7, 32'h0000_0000, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 3'd1, 32'h0000_0102, 1'b1, 5'd3,  32'h0000_0033, 1'b0, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF};
    vecs[6] = '{1'b1, 3'd2, 32'h0000_0101, 1'b1, 5'd4,  32'h0000_0044, 1'b0, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 3'd2, 32'h0000_0203, 1'b1, 5'd8,  32'h0000_0055, 1'b0, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF};

    rst = 1'b1; inValid = 1'b0; memOp = 3'd0; memAddr_i = 32'h0; storeData = 32'h0;
    regcWr_i = 1'b0; regcAddr_i = 5'd0; regcData_i = 32'h0; memRData = 32'h0; memAck = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_regcWr", regcWr, 0);
    check("rst_regcAddr", regcAddr, 0);
    check("rst_regcData", regcData, 0);
    check("rst_memCe", memCe, 0);
    check("rst_memWe", memWe, 0);
    check("rst_memBe", memBe, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_memWData", memWData, 0);
    check("rst_stall", stall, 0);
    check("rst_alignErr", alignErr, 0);
    check("rst_busErr", busErr, 0);
    check("rst_state", dbg_state_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle IDLE vectors
    for (int i = 0; i < 8; i++) begin
      inValid = vecs[i].v; memOp = vecs[i].op; memAddr_i = vecs[i].addr;
      regcWr_i = vecs[i].wr; regcAddr_i = vecs[i].ra; regcData_i = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
      check($sformatf("vec%0d_alignErr", i), alignErr, vecs[i].e_align);
      check($sformatf("vec%0d_memCe_pre", i), memCe, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_regcWr", i), regcWr, vecs[i].e_wr);
      check($sformatf("vec%0d_regcAddr", i), regcAddr, vecs[i].e_ra);
      check($sformatf("vec%0d_regcData", i), regcData, vecs[i].e_rd);
      check($sformatf("vec%0d_memCe_post", i), memCe, 0);
      check($sformatf("vec%0d_state", i), dbg_state_o, 0);
    end
    inValid = 1'b0; memOp = 3'd0;
    @(posedge clk); #1;

    // LW 0x100, ack in fourth WAIT cycle
    do_access(3'd1, 32'h0000_0100, 32'h0, 5'd4, 4, 32'h1234_5678);
    check("lw_ce_idle", g_ce_idle, 0);
    check("lw_stall_cycles", g_stall, 4);
    check("lw_ce", g_ce, 1);
    check("lw_we", g_we, 0);
    check("lw_be", g_be, 4'b1111);
    check("lw_addr", g_addr, 32'h0000_0100);
    check("lw_stable", g_stable, 1);
    check("lw_wr_wait", g_wr_wait, 0);
    check("lw_busErr", g_bus, 0);
    check("lw_regcWr", regcWr, 1);
    check("lw_regcAddr", regcAddr, 5'd4);
    check("lw_regcData", regcData, 32'h1234_5678);
    check("lw_ce_after", g_ce_after, 0);

    // LB / LBU on lane 3
    do_access(3'd3, 32'h0000_0103, 32'h0, 5'd10, 1, 32'h80FF_0000);
    check("lb_be", g_be, 4'b1000);
    check("lb_addr", g_addr, 32'h0000_0100);
    check("lb_regcWr", regcWr, 1);
    check("lb_regcAddr", regcAddr, 5'd10);
    check("lb_regcData", regcData, 32'hFFFF_FF80);
    do_access(3'd4, 32'h0000_0103, 32'h0, 5'd11, 2, 32'h80FF_0000);
    check("lbu_be", g_be, 4'b1000);
    check("lbu_regcAddr", regcAddr, 5'd11);
    check("lbu_regcData", regcData, 32'h0000_0080);
    do_access(3'd3, 32'h0000_0101, 32'h0, 5'd12, 1, 32'h1234_7F56);
    check("lb_pos_be", g_be, 4'b0010);
    check("lb_pos_regcData", regcData, 32'h0000_007F);

    // SB on lane 1
    do_access(3'd5, 32'h0000_0201, 32'hAABB_CCDD, 5'd13, 2, 32'h0);
    check("sb_be", g_be, 4'b0010);
    check("sb_wdata", g_wdata, 32'hDDDD_DDDD);
    check("sb_we", g_we, 1);
    check("sb_addr", g_addr, 32'h0000_0200);
    check("sb_stable", g_stable, 1);
    check("sb_regcWr", regcWr, 0);
    check("sb_regcData_hold", regcData, 32'h0000_007F);

    // SW with no ack: timeout on the 16th WAIT cycle
    do_access(3'd2, 32'h0000_0300, 32'h0123_4567, 5'd14, 0, 32'h0);
    check("swto_waits", g_waits, 16);
    check("swto_busErr", g_bus, 1);
    check("swto_stall_cycles", g_stall, 16);
    check("swto_we", g_we, 1);
    check("swto_wdata", g_wdata, 32'h0123_4567);
    check("swto_stable", g_stable, 1);
    check("swto_ce_after", g_ce_after, 0);
    check("swto_regcWr", regcWr, 0);
    check("swto_busErr_after", busErr, 0);

    // SW acked on the last allowed cycle counts as success
    do_access(3'd2, 32'h0000_0300, 32'h0123_4567, 5'd14, 16, 32'h0);
    check("swack16_waits", g_waits, 16);
    check("swack16_busErr", g_bus, 0);
    check("swack16_be", g_be, 4'b1111);
    check("swack16_regcWr", regcWr, 0);
    check("swack16_ce_after", g_ce_after, 0);

    // LW acked on the last allowed cycle writes back
    do_access(3'd1, 32'h0000_0040, 32'h0, 5'd21, 16, 32'hCAFE_F00D);
    check("lwack16_busErr", g_bus, 0);
    check("lwack16_regcWr", regcWr, 1);
    check("lwack16_regcData", regcData, 32'hCAFE_F00D);

    // Reset in the middle of WAIT, then a stray ack in IDLE
    inValid = 1'b1; memOp = 3'd1; memAddr_i = 32'h0000_0400;
    regcWr_i = 1'b1; regcAddr_i = 5'd9; regcData_i = 32'h0;
    @(posedge clk); #1;
    inValid = 1'b0; memOp = 3'd0;
    #1;
    check("rstw_ce_before", memCe, 1);
    check("rstw_stall_before", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_ce", memCe, 0);
    check("rstw_stall", stall, 0);
    check("rstw_be", memBe, 0);
    check("rstw_busErr", busErr, 0);
    check("rstw_state", dbg_state_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    memAck = 1'b1; memRData = 32'hFFFF_FFFF;
    #1;
    check("idleack_stall", stall, 0);
    check("idleack_busErr", busErr, 0);
    check("idleack_ce", memCe, 0);
    @(posedge clk); #1;
    memAck = 1'b0;
    check("rstw_regcWr", regcWr, 0);
    check("rstw_regcData", regcData, 0);
    check("rstw_state_after", dbg_state_o, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rstw_regcWr_late", regcWr, 0);
    check("rstw_busErr_late", busErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
